rfblackwidow_pma_checker: RTL and testbench

RFBLACKWIDOW_PMA_CHECKER -- requirements
Module: rfblackwidow_pma_checker

---
 rtl/rfblackwidow_pma_checker.sv | 180 ++++++++++++++++++
 tb/tb_rfblackwidow_pma_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rfblackwidow_pma_checker.sv
// PMA checker: arbitrates one region-table port among instruction fetch, data and config writers.
// Latency: lookup request granted at edge N is acked after edge N+2; config write acked after edge N+1.
// Backpressure: requesters hold req/adr until their ack; losers and late arrivals simply wait in place.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   if_req/if_adr -> if_ack/fault/cache instruction-fetch requester (execute permission)
//   dm_req/dm_we/dm_adr -> dm_ack/...   data requester (write or read permission)
//   cfg_req/cfg_rwa/cfg_dat -> cfg_ack  region-table write requester
//   fault_code, rgn_num_o               details of the last completed check
//   rgn_adr/rgn_wr/rgn_rwa/rgn_dat      region-table port; rgn_at/rgn_num/rgn_err return combinationally
module rfblackwidow_pma_checker #(
   parameter int AWID = 32,
   parameter int ATW  = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_req,
   input  logic [AWID-1:0] if_adr,
   output logic            if_ack,
   output logic            if_fault,
   output logic            if_cache,
   input  logic            dm_req,
   input  logic            dm_we,
   input  logic [AWID-1:0] dm_adr,
   output logic            dm_ack,
   output logic            dm_fault,
   output logic            dm_cache,
   input  logic            cfg_req,
   input  logic [5:0]      cfg_rwa,
   input  logic [63:0]     cfg_dat,
   output logic            cfg_ack,
   output logic [1:0]      fault_code,
   output logic [3:0]      rgn_num_o,
   output logic [AWID-1:0] rgn_adr,
   output logic            rgn_wr,
   output logic [5:0]      rgn_rwa,
   output logic [63:0]     rgn_dat,
   input  logic [ATW-1:0]  rgn_at,
   input  logic [3:0]      rgn_num,
   input  logic            rgn_err
);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP, S_CFG} state_t;

   state_t      state, state_nxt;
   logic        gnt_cfg, gnt_if, gnt_dm;
   logic        last_dm;      // 1: dm was granted most recently
   logic        sel_dm;       // requester owning the lookup in flight
   logic [1:0]  perm_idx;     // rgn_at bit required: 0 exec, 1 write, 2 read
   logic        r_fault, r_cache;
   logic [1:0]  r_code;
   logic [3:0]  r_num;

   // The ack cycle is spent in IDLE with req still high; masking the acked
   // requester keeps that same request from being granted twice.
   logic cfg_pend, if_pend, dm_pend;
   assign cfg_pend = cfg_req & ~cfg_ack;
   assign if_pend  = if_req  & ~if_ack;
   assign dm_pend  = dm_req  & ~dm_ack;

   logic       perm_ok, lk_fault, lk_cache;
   logic [1:0] lk_code;
   assign perm_ok  = rgn_at[perm_idx];
   assign lk_fault = rgn_err | ~perm_ok;
   assign lk_code  = rgn_err ? 2'd1 : (perm_ok ? 2'd0 : 2'd2);
   assign lk_cache = rgn_at[3] & ~lk_fault;

   // Attribute bits above the cacheable flag carry nothing this checker uses.
   logic unused_at;
   assign unused_at = ^rgn_at[ATW-1:4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      gnt_cfg   = 1'b0;
      gnt_if    = 1'b0;
      gnt_dm    = 1'b0;
      case (state)
         S_IDLE: begin
            if (cfg_pend) begin
               gnt_cfg   = 1'b1;
               state_nxt = S_CFG;
            end else if (if_pend && (!dm_pend || last_dm)) begin
               gnt_if    = 1'b1;
               state_nxt = S_LOOKUP;
            end else if (dm_pend) begin
               gnt_dm    = 1'b1;
               state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         S_CFG:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_dm    <= 1'b1;
         sel_dm     <= 1'b0;
         perm_idx   <= 2'd0;
         r_fault    <= 1'b0;
         r_cache    <= 1'b0;
         r_code     <= 2'd0;
         r_num      <= 4'd0;
         if_ack     <= 1'b0;
         if_fault   <= 1'b0;
         if_cache   <= 1'b0;
         dm_ack     <= 1'b0;
         dm_fault   <= 1'b0;
         dm_cache   <= 1'b0;
         cfg_ack    <= 1'b0;
         fault_code <= 2'd0;
         rgn_num_o  <= 4'd0;
         rgn_adr    <= '0;
         rgn_wr     <= 1'b0;
         rgn_rwa    <= 6'd0;
         rgn_dat    <= 64'd0;
      end else begin
         // Response strobes are single-cycle pulses.
         if_ack   <= 1'b0;
         if_fault <= 1'b0;
         if_cache <= 1'b0;
         dm_ack   <= 1'b0;
         dm_fault <= 1'b0;
         dm_cache <= 1'b0;
         cfg_ack  <= 1'b0;
         rgn_wr   <= 1'b0;

         if (gnt_cfg) begin
            rgn_wr  <= 1'b1;
            rgn_rwa <= cfg_rwa;
            rgn_dat <= cfg_dat;
         end
         if (gnt_if) begin
            rgn_adr  <= if_adr;
            sel_dm   <= 1'b0;
            perm_idx <= 2'd0;
            last_dm  <= 1'b0;
         end
         if (gnt_dm) begin
            rgn_adr  <= dm_adr;
            sel_dm   <= 1'b1;
            perm_idx <= dm_we ? 2'd1 : 2'd2;
            last_dm  <= 1'b1;
         end

         case (state)
            S_LOOKUP: begin
               r_fault <= lk_fault;
               r_cache <= lk_cache;
               r_code  <= lk_code;
               r_num   <= rgn_num;
            end
            S_RESP: begin
               if (sel_dm) begin
                  dm_ack   <= 1'b1;
                  dm_fault <= r_fault;
                  dm_cache <= r_cache;
               end else begin
                  if_ack   <= 1'b1;
                  if_fault <= r_fault;
                  if_cache <= r_cache;
               end
               fault_code <= r_code;
               rgn_num_o  <= r_num;
            end
            S_CFG:   cfg_ack <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rfblackwidow_pma_checker.sv
// Bench for rfblackwidow_pma_checker: directed transactions, a region-table model
// answering lookups, and a per-cycle compare against permission rules.
module tb_rfblackwidow_pma_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_ack, if_fault, if_cache;
   logic [31:0] if_adr;
   logic        dm_req, dm_we, dm_ack, dm_fault, dm_cache;
   logic [31:0] dm_adr;
   logic        cfg_req, cfg_ack;
   logic [5:0]  cfg_rwa;
   logic [63:0] cfg_dat;
   logic [1:0]  fault_code;
   logic [3:0]  rgn_num_o;
   logic [31:0] rgn_adr;
   logic        rgn_wr;
   logic [5:0]  rgn_rwa;
   logic [63:0] rgn_dat;
   logic [19:0] rgn_at;
   logic [3:0]  rgn_num;
   logic        rgn_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rfblackwidow_pma_checker #(.AWID(32), .ATW(20)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_adr(if_adr), .if_ack(if_ack), .if_fault(if_fault), .if_cache(if_cache),
      .dm_req(dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_ack(dm_ack), .dm_fault(dm_fault),
      .dm_cache(dm_cache),
      .cfg_req(cfg_req), .cfg_rwa(cfg_rwa), .cfg_dat(cfg_dat), .cfg_ack(cfg_ack),
      .fault_code(fault_code), .rgn_num_o(rgn_num_o),
      .rgn_adr(rgn_adr), .rgn_wr(rgn_wr), .rgn_rwa(rgn_rwa), .rgn_dat(rgn_dat),
      .rgn_at(rgn_at), .rgn_num(rgn_num), .rgn_err(rgn_err)
   );

   // Region table: {err, num[3:0], at[19:0]}
   function automatic logic [24:0] region(input logic [31:0] a);
      if (a[31:16] == 16'h0000)      return {1'b0, 4'd1, 20'h0010F};
      else if (a[31:16] == 16'hFFFD) return {1'b0, 4'd2, 20'h0000D};
      else if (a[31:28] == 4'h2)     return {1'b0, 4'd3, 20'h00007};
      else                           return {1'b1, 4'd0, 20'h00000};
   endfunction

   assign {rgn_err, rgn_num, rgn_at} = region(rgn_adr);

   // Expected {fault, cache, code[1:0], num[3:0]}; acc: 0 exec, 1 write, 2 read.
   function automatic logic [7:0] model(input logic [31:0] a, input int acc);
      logic [24:0] r;
      logic [19:0] at;
      logic        allowed;
      r  = region(a);
      at = r[19:0];
      allowed = (acc == 0) ? at[0] : (acc == 1) ? at[1] : at[2];
      if (r[24])        return {1'b1, 1'b0, 2'd1, r[23:20]};
      else if (!allowed) return {1'b1, 1'b0, 2'd2, r[23:20]};
      else              return {1'b0, at[3], 2'd0, r[23:20]};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 if, 1 dm, 2 cfg; lat = cycles until ack seen, 0 on timeout
   task automatic wait_ack(input int which, output int lat);
      lat = 0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if ((which == 0 && if_ack) || (which == 1 && dm_ack) || (which == 2 && cfg_ack)) begin
            lat = c;
            break;
         end
      end
   endtask

   // Per-cycle compare against the permission rules.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outs",
             {if_ack, if_fault, if_cache, dm_ack, dm_fault, dm_cache, cfg_ack, rgn_wr,
              fault_code, rgn_num_o, rgn_adr, rgn_rwa, rgn_dat}, '0);
      end else begin
         chk("one_ack", {if_ack, dm_ack} == 2'b11, 1'b0);
         if (if_ack)
            chk("if_resp", {if_fault, if_cache, fault_code, rgn_num_o}, model(if_adr, 0));
         else
            chk("if_quiet", {if_fault, if_cache}, 2'b00);
         if (dm_ack)
            chk("dm_resp", {dm_fault, dm_cache, fault_code, rgn_num_o}, model(dm_adr, dm_we ? 1 : 2));
         else
            chk("dm_quiet", {dm_fault, dm_cache}, 2'b00);
         if (rgn_wr)
            chk("cfg_wr", {rgn_rwa, rgn_dat}, {cfg_rwa, cfg_dat});
      end
   end

   initial begin
      int lat;
      int ack_cyc[$];
      int ack_who[$];

      rst_n = 1'b0;
      if_req = 0; if_adr = 0; dm_req = 0; dm_we = 0; dm_adr = 0;
      cfg_req = 0; cfg_rwa = 0; cfg_dat = 0;

      // Reset state
      tick(); tick();
      chk("rst_fault_code", fault_code, 2'd0);
      chk("rst_rgn_adr", rgn_adr, 32'd0);
      chk("rst_acks", {if_ack, dm_ack, cfg_ack, rgn_wr}, 4'd0);

      // Fetch, executable cacheable region; first grant on first edge after release
      rst_n = 1'b1;
      if_adr = 32'h0000_1000; if_req = 1;
      wait_ack(0, lat);
      if_req = 0;
      chk("t1_lat", lat, 3);
      chk("t1_fault", if_fault, 1'b0);
      chk("t1_cache", if_cache, 1'b1);
      chk("t1_num", rgn_num_o, 4'd1);
      chk("t1_code", fault_code, 2'd0);
      tick();

      // Data write to a non-writable region
      dm_adr = 32'hFFFD_0100; dm_we = 1; dm_req = 1;
      wait_ack(1, lat);
      dm_req = 0;
      chk("t2_lat", lat, 3);
      chk("t2_fault", dm_fault, 1'b1);
      chk("t2_code", fault_code, 2'd2);
      chk("t2_cache", dm_cache, 1'b0);
      chk("t2_num", rgn_num_o, 4'd2);
      tick();

      // Data read with no matching region
      dm_adr = 32'h4000_0000; dm_we = 0; dm_req = 1;
      wait_ack(1, lat);
      dm_req = 0;
      chk("t3_lat", lat, 3);
      chk("t3_fault", dm_fault, 1'b1);
      chk("t3_code", fault_code, 2'd1);
      tick();

      // Both requesters held from reset: if, dm, if, dm every 3 cycles
      rst_n = 1'b0;
      if_adr = 32'h0000_2000; dm_adr = 32'h2000_0010; dm_we = 0;
      if_req = 1; dm_req = 1;
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (if_ack) begin ack_cyc.push_back(c); ack_who.push_back(0); end
         if (dm_ack) begin ack_cyc.push_back(c); ack_who.push_back(1); end
      end
      if_req = 0; dm_req = 0;
      chk("t4_count", ack_cyc.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < ack_cyc.size()) begin
            chk($sformatf("t4_cyc%0d", i), ack_cyc[i], 3 * (i + 1));
            chk($sformatf("t4_who%0d", i), ack_who[i], i % 2);
         end
      end
      repeat (5) tick();

      // Config write beats a simultaneous fetch
      cfg_rwa = 6'o14; cfg_dat = 64'h206; cfg_req = 1;
      if_adr = 32'h0000_1000; if_req = 1;
      tick();
      chk("t5_wr", rgn_wr, 1'b1);
      chk("t5_rwa", rgn_rwa, 6'o14);
      chk("t5_dat", rgn_dat, 64'h206);
      chk("t5_noack", {cfg_ack, if_ack}, 2'b00);
      tick();
      chk("t5_wr_off", rgn_wr, 1'b0);
      chk("t5_cfg_ack", cfg_ack, 1'b1);
      cfg_req = 0;
      wait_ack(0, lat);
      if_req = 0;
      chk("t5_if_lat", lat, 3);
      tick();

      // Reset during LOOKUP abandons the transaction
      if_adr = 32'h0000_1000; if_req = 1;
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_adr", rgn_adr, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("t6_no_ack", if_ack, 1'b0);
      end
      rst_n = 1'b1;
      wait_ack(0, lat);
      if_req = 0;
      chk("t6_lat", lat, 3);
      tick();

      // cfg, if and dm together; last grant was if, so dm precedes if
      ack_cyc.delete(); ack_who.delete();
      cfg_rwa = 6'o21; cfg_dat = 64'h1234; cfg_req = 1;
      if_adr = 32'h0000_2000; if_req = 1;
      dm_adr = 32'hFFFD_0100; dm_we = 0; dm_req = 1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (cfg_ack) begin ack_cyc.push_back(c); ack_who.push_back(2); cfg_req = 0; end
         if (if_ack)  begin ack_cyc.push_back(c); ack_who.push_back(0); if_req = 0; end
         if (dm_ack)  begin ack_cyc.push_back(c); ack_who.push_back(1); dm_req = 0; end
      end
      cfg_req = 0; if_req = 0; dm_req = 0;
      chk("t7_count", ack_cyc.size(), 3);
      if (ack_cyc.size() == 3) begin
         chk("t7_order", {ack_who[0][1:0], ack_who[1][1:0], ack_who[2][1:0]}, 6'b10_01_00);
         chk("t7_cycles", {ack_cyc[0][7:0], ack_cyc[1][7:0], ack_cyc[2][7:0]}, {8'd2, 8'd5, 8'd8});
      end
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
